// File: rtl/packed_serializer.sv
// ----------------------------------------------------------------------------
// packed_serializer
//
// Parallel-to-serial converter. A WIDTH-bit word is accepted over a
// valid/ready handshake and shifted out one bit per enabled clock. This is
// the transmit-side partner of the bit-per-clock packed-array deserializer,
// so the two can be wired back-to-back for loopback.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   LSB_FIRST  1: bit 0 leaves first; 0: bit WIDTH-1 leaves first
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (drops any word in flight)
//   i_valid  producer presents a word on i_data
//   i_data   word to serialize, sampled only at the accept edge
//   o_ready  word on i_data is taken at this edge if i_valid is high
//   i_en     sink consumes the current serial bit at this edge
//   o_a      current serial bit (driven from registers only)
//   o_valid  o_a carries a valid bit
//   o_last   o_a is the final bit of the current word
// ----------------------------------------------------------------------------
module packed_serializer #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ready,
   input  logic             i_en,
   output logic             o_a,
   output logic             o_valid,
   output logic             o_last
);

   localparam int                IDX_W    = $clog2(WIDTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic               at_last;
   logic               accept;

   // Bit currently on the wire for a given position in the word.
   function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                     input logic [IDX_W-1:0] pos);
      if (LSB_FIRST) begin
         return word[pos];
      end else begin
         return word[LAST_IDX - pos];
      end
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         sreg_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sreg_q  <= sreg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sreg_d  = sreg_q;

      at_last = (state_q == SHIFT) && (idx_q == LAST_IDX);
      // Ready during the last bit lets the next word follow with no bubble;
      // i_en -> o_ready is the only combinational path through the block.
      o_ready = (state_q == IDLE) || (at_last && i_en);
      accept  = i_valid && o_ready;

      o_valid = (state_q == SHIFT);
      o_last  = at_last;
      o_a     = o_valid ? pick_bit(sreg_q, idx_q) : 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sreg_d  = i_data;
               idx_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // With i_en low everything holds, so the outputs stay stable.
            if (i_en) begin
               if (!at_last) begin
                  idx_d = idx_q + IDX_ONE;
               end else if (accept) begin
                  sreg_d = i_data;
                  idx_d  = '0;
               end else begin
                  idx_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

endmodule

// File: doc/packed_serializer.md
Name: packed_serializer

Overview:
- Parallel-to-serial converter: the transmit-side counterpart of the bit-per-clock packed-array deserializer in the interface library.
- Accepts a WIDTH-bit packed word over a valid/ready handshake and emits it one bit per enabled clock on a serial output.
- Sits between a word-wide producer and any serial sink that writes one bit location per rising edge, so the two blocks can be connected back-to-back in loopback benches.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  producer presents a word on i_data.
- i_data  input  WIDTH  word to serialize.
- o_ready  output  1  block accepts i_data at this edge if i_valid is high.
- i_en  input  1  sink consumes the current serial bit at this edge.
- o_a  output  1  current serial bit.
- o_valid  output  1  o_a carries a valid bit.
- o_last  output  1  o_a is the final bit of the current word.

Behaviour:
- State: {IDLE, SHIFT}. Also a WIDTH-bit shift-hold register sreg and an index counter idx of width $clog2(WIDTH).
- Reset (async assert, sync release): state=IDLE, idx=0, sreg=0, o_valid=0, o_a=0, o_last=0, o_ready=1. Asserting reset mid-word drops the word; there is no partial flush.
- Accept condition: i_valid && o_ready at a rising edge. On accept: sreg<=i_data, idx<=0, state<=SHIFT.
- o_ready = (state==IDLE) || (state==SHIFT && idx==WIDTH-1 && i_en). This is the only combinational input-to-output path (i_en -> o_ready).
- o_valid = (state==SHIFT).
- o_a = sreg[idx] when LSB_FIRST=1, else sreg[WIDTH-1-idx]; 0 in IDLE. o_a depends on registers only.
- o_last = o_valid && idx==WIDTH-1.
- SHIFT, i_en=1, idx<WIDTH-1: idx<=idx+1.
- SHIFT, i_en=1, idx==WIDTH-1:
  - With accept: load the new word, idx<=0, stay in SHIFT. There is no bubble between words.
  - Without accept: state<=IDLE, idx<=0.
- SHIFT, i_en=0: idx, sreg and state hold, and all outputs are stable (stall).
- Latency: a word accepted at edge N drives its first bit during the cycle after edge N. With i_en held high, bits occupy cycles N+1 .. N+WIDTH.
- i_valid while o_ready=0: ignored. sreg is not modified and the producer must hold i_valid and i_data.
- i_data is sampled only at the accept edge; later changes have no effect.
- idx never exceeds WIDTH-1. There is no wrap-around beyond the last bit, and the counter resets on every load.

Test Plan:
- Reset values: assert i_rst_n=0 asynchronously between clock edges -> o_valid=0, o_a=0, o_last=0, o_ready=1 immediately.
- Single word, WIDTH=8, LSB_FIRST=1, i_en=1: accept 0xA5 -> o_a = 1,0,1,0,0,1,0,1 over 8 cycles; o_last only on the 8th; then o_valid=0.
- Back-to-back: 0xA5 then 0x3C with i_valid held high -> 16 contiguous o_valid cycles; o_ready=1 only in IDLE and on each last-bit cycle; the second word's bits are 0,0,1,1,1,1,0,0.
- Stall: i_en=0 for 3 cycles at idx=3 of 0xA5 -> o_a holds 0 and idx holds for 3 cycles; the remaining bits are unchanged; o_ready stays 0 at idx=7 while i_en=0.
- Busy ignore plus reset mid-word: pulse i_valid with 0xFF at idx=2 of 0x00 -> only zeros are sent. Then assert reset at idx=5 -> outputs clear at once; after release, the next word 0x81 serializes cleanly.
- LSB_FIRST=0: accept 0xA5 -> o_a = 1,0,1,0,0,1,0,1 (MSB first); accept 0x01 -> seven 0s then 1 with o_last.
